// File: rtl/board_pkg.sv
// Shared board types and the 3x3 neighbourhood offset table used by the
// mine-count and flood-reveal engines.
package board_pkg;

  localparam int unsigned DEF_MAX_DIM = 16;
  localparam int unsigned DEF_COORD_W = $clog2(DEF_MAX_DIM);
  localparam int unsigned DEF_CNT_W   = 4;

  typedef logic [DEF_COORD_W-1:0] coord_t;
  typedef logic [DEF_CNT_W-1:0]   count_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    NEXT = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } offset_t;

  // k walks the 3x3 window row-major: dx = k%3-1, dy = k/3-1
  function automatic offset_t offset_of(input logic [3:0] k);
    offset_t o;
    case (k)
      4'd0, 4'd3, 4'd6: o.dx = 2'sb11;
      4'd1, 4'd4, 4'd7: o.dx = 2'sb00;
      default:          o.dx = 2'sb01;
    endcase
    case (k)
      4'd0, 4'd1, 4'd2: o.dy = 2'sb11;
      4'd3, 4'd4, 4'd5: o.dy = 2'sb00;
      default:          o.dy = 2'sb01;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/neighbour_addr_gen.sv
// Maps (centre, k, dim) to one neighbour coordinate and flags whether it lies
// on the active board; the centre itself (k = 4) is never in bounds.
module neighbour_addr_gen
  import board_pkg::*;
#(
  parameter int unsigned COORD_W = DEF_COORD_W
) (
  input  logic [COORD_W-1:0] centre_x,
  input  logic [COORD_W-1:0] centre_y,
  input  logic [3:0]         k,
  input  logic [COORD_W:0]   dim,
  output logic [COORD_W-1:0] nb_x,
  output logic [COORD_W-1:0] nb_y,
  output logic               in_bounds
);

  localparam int unsigned SW = COORD_W + 2;

  offset_t              off;
  logic signed [SW-1:0] sx;
  logic signed [SW-1:0] sy;
  logic signed [SW-1:0] sdim;

  // Two guard bits keep -1 and MAX_DIM representable, so no wrap at either edge
  always_comb begin
    off       = offset_of(k);
    sx        = $signed({2'b00, centre_x}) + $signed({{COORD_W{off.dx[1]}}, off.dx});
    sy        = $signed({2'b00, centre_y}) + $signed({{COORD_W{off.dy[1]}}, off.dy});
    sdim      = $signed({1'b0, dim});
    nb_x      = sx[COORD_W-1:0];
    nb_y      = sy[COORD_W-1:0];
    in_bounds = (k != 4'd4) && (k <= 4'd8) &&
                !sx[SW-1] && (sx < sdim) &&
                !sy[SW-1] && (sy < sdim);
  end

endmodule

// File: rtl/neighbour_count_engine.sv
// Counts mines around one cell or every cell of a square board of run-time
// size, streaming each result out with a one-cycle res_valid strobe.
module neighbour_count_engine
  import board_pkg::*;
#(
  parameter int unsigned MAX_DIM = DEF_MAX_DIM,
  parameter int unsigned COORD_W = $clog2(MAX_DIM),
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sweep,
  input  logic                       abort,
  input  logic [COORD_W:0]           board_dim,
  input  logic [COORD_W-1:0]         cell_x,
  input  logic [COORD_W-1:0]         cell_y,
  input  logic [MAX_DIM*MAX_DIM-1:0] mine_arr,
  output logic                       busy,
  output logic                       res_valid,
  output logic [COORD_W-1:0]         res_x,
  output logic [COORD_W-1:0]         res_y,
  output logic [CNT_W-1:0]           res_count,
  output logic                       res_is_mine,
  output logic                       res_err,
  output logic                       sweep_done
);

  localparam int unsigned CELLS = MAX_DIM * MAX_DIM;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam logic [COORD_W:0] DIM_MAX = (COORD_W+1)'(MAX_DIM);

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W:0]   dim_q, dim_d;
  logic               sweep_q, sweep_d;
  logic [CNT_W-1:0]   acc_q, acc_d;

  logic               busy_d, valid_d, done_d, mine_d, err_d;
  logic [COORD_W-1:0] rx_d, ry_d;
  logic [CNT_W-1:0]   count_d;

  logic [COORD_W-1:0] nb_x, nb_y;
  logic               in_bounds;
  logic [IDX_W-1:0]   nb_idx, centre_idx;
  logic               hit;
  logic [COORD_W:0]   dim_clamped;
  logic               req_oob;
  logic               x_at_edge, last_cell;

  neighbour_addr_gen #(
    .COORD_W (COORD_W)
  ) u_addr_gen (
    .centre_x  (cx_q),
    .centre_y  (cy_q),
    .k         (k_q),
    .dim       (dim_q),
    .nb_x      (nb_x),
    .nb_y      (nb_y),
    .in_bounds (in_bounds)
  );

  // Bitmap lookups and request qualification
  always_comb begin
    nb_idx      = IDX_W'(nb_y) * IDX_W'(MAX_DIM) + IDX_W'(nb_x);
    centre_idx  = IDX_W'(cy_q) * IDX_W'(MAX_DIM) + IDX_W'(cx_q);
    hit         = in_bounds && mine_arr[nb_idx];
    dim_clamped = (board_dim > DIM_MAX) ? DIM_MAX : board_dim;
    req_oob     = ({1'b0, cell_x} >= dim_clamped) || ({1'b0, cell_y} >= dim_clamped);
    x_at_edge   = ({1'b0, cx_q} == dim_q - (COORD_W+1)'(1));
    last_cell   = x_at_edge && ({1'b0, cy_q} == dim_q - (COORD_W+1)'(1));
  end

  // Next-state and next-output logic; result registers load on entry to EMIT
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dim_d   = dim_q;
    sweep_d = sweep_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rx_d    = res_x;
    ry_d    = res_y;
    count_d = res_count;
    mine_d  = res_is_mine;
    err_d   = res_err;

    case (state_q)
      IDLE: begin
        if (start && !abort && (board_dim != '0)) begin
          dim_d   = dim_clamped;
          sweep_d = sweep;
          k_d     = 4'd0;
          acc_d   = '0;
          if (sweep) begin
            cx_d    = '0;
            cy_d    = '0;
            state_d = SCAN;
          end else begin
            cx_d = cell_x;
            cy_d = cell_y;
            if (req_oob) begin
              state_d = EMIT;
              valid_d = 1'b1;
              rx_d    = cell_x;
              ry_d    = cell_y;
              count_d = '0;
              mine_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              state_d = SCAN;
            end
          end
        end
      end

      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + CNT_W'(hit);
          k_d   = k_q + 4'd1;
          if (k_q == 4'd8) begin
            state_d = EMIT;
            valid_d = 1'b1;
            rx_d    = cx_q;
            ry_d    = cy_q;
            count_d = acc_q + CNT_W'(hit);
            mine_d  = mine_arr[centre_idx];
            err_d   = 1'b0;
            done_d  = sweep_q && last_cell;
          end
        end
      end

      EMIT: begin
        if (abort || !sweep_q || last_cell) begin
          state_d = IDLE;
        end else begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          k_d     = 4'd0;
          acc_d   = '0;
          if (x_at_edge) begin
            cx_d = '0;
            cy_d = cy_q + COORD_W'(1);
          end else begin
            cx_d = cx_q + COORD_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      dim_q       <= '0;
      sweep_q     <= 1'b0;
      acc_q       <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_x       <= '0;
      res_y       <= '0;
      res_count   <= '0;
      res_is_mine <= 1'b0;
      res_err     <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      dim_q       <= dim_d;
      sweep_q     <= sweep_d;
      acc_q       <= acc_d;
      busy        <= busy_d;
      res_valid   <= valid_d;
      res_x       <= rx_d;
      res_y       <= ry_d;
      res_count   <= count_d;
      res_is_mine <= mine_d;
      res_err     <= err_d;
      sweep_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_neighbour_count_engine.sv
// Directed bench for neighbour_count_engine: single, out-of-bounds, clamp,
// full sweep, abort and asynchronous reset scenarios.
module tb_neighbour_count_engine;

  localparam int MD = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sweep, abort;
  logic [4:0]   board_dim;
  logic [3:0]   cell_x, cell_y;
  logic [255:0] mine_arr;
  logic         busy, res_valid, res_is_mine, res_err, sweep_done;
  logic [3:0]   res_x, res_y, res_count;

  int errors = 0;
  int checks = 0;

  neighbour_count_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sweep       (sweep),
    .abort       (abort),
    .board_dim   (board_dim),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .mine_arr    (mine_arr),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_x       (res_x),
    .res_y       (res_y),
    .res_count   (res_count),
    .res_is_mine (res_is_mine),
    .res_err     (res_err),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mine(input int x, input int y);
    mine_arr[y*MD+x] = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,        0);
    check({tag, "_valid"}, res_valid,   0);
    check({tag, "_x"},     res_x,       0);
    check({tag, "_y"},     res_y,       0);
    check({tag, "_count"}, res_count,   0);
    check({tag, "_mine"},  res_is_mine, 0);
    check({tag, "_err"},   res_err,     0);
    check({tag, "_done"},  sweep_done,  0);
  endtask

  // Start in cycle T; busy T+1..T+10, result strobe exactly at T+10
  task automatic run_single(input int dim, input int x, input int y,
                            input int exp_cnt, input int exp_mine, input string tag);
    board_dim = 5'(dim);
    cell_x    = 4'(x);
    cell_y    = 4'(y);
    sweep     = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      check({tag, "_busy"},  busy,      1);
      check({tag, "_valid"}, res_valid, (c == 10));
    end
    check({tag, "_count"}, res_count,   exp_cnt);
    check({tag, "_mine"},  res_is_mine, exp_mine);
    check({tag, "_err"},   res_err,     0);
    check({tag, "_x"},     res_x,       x);
    check({tag, "_y"},     res_y,       y);
    check({tag, "_done"},  sweep_done,  0);
    tick();
    check({tag, "_idle_busy"},  busy,      0);
    check({tag, "_idle_valid"}, res_valid, 0);
    check({tag, "_hold_count"}, res_count, exp_cnt);
  endtask

  task automatic start_sweep(input int dim);
    board_dim = 5'(dim);
    sweep     = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    sweep = 1'b0;
  endtask

  initial begin
    int pulses;
    int ex, ey, exp_cnt;
    logic exp_v;

    rst_n     = 1'b0;
    start     = 1'b0;
    sweep     = 1'b0;
    abort     = 1'b0;
    board_dim = '0;
    cell_x    = '0;
    cell_y    = '0;
    mine_arr  = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Corner of an 8x8 board; far mine (7,7) must not count
    mine_arr = '0;
    set_mine(1, 0); set_mine(0, 1); set_mine(1, 1); set_mine(7, 7);
    run_single(8, 0, 0, 3, 0, "corner");

    // Far edge of the largest board: no wrap to column/row 0
    mine_arr = '0;
    set_mine(0, 0); set_mine(0, 15); set_mine(15, 0);
    run_single(16, 15, 15, 0, 0, "far_edge");

    // Mine just outside a 10x10 board
    mine_arr = '0;
    set_mine(10, 9);
    run_single(10, 9, 9, 0, 0, "dim10_edge");

    // Full neighbourhood plus centre mine
    mine_arr = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        set_mine(5 + dx, 5 + dy);
    run_single(10, 5, 5, 8, 1, "max_count");

    // Out-of-bounds request answers at T+1 with the error flag
    mine_arr = '0;
    set_mine(8, 3); set_mine(7, 3);
    board_dim = 5'd8;
    cell_x    = 4'd8;
    cell_y    = 4'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("oob_valid", res_valid,   1);
    check("oob_err",   res_err,     1);
    check("oob_count", res_count,   0);
    check("oob_mine",  res_is_mine, 0);
    check("oob_busy",  busy,        1);
    check("oob_x",     res_x,       8);
    check("oob_y",     res_y,       3);
    tick();
    check("oob_after_valid", res_valid, 0);
    check("oob_after_busy",  busy,      0);
    check("oob_hold_err",    res_err,   1);

    // Oversized dimension clamps to 16; unclamped would alias column/row 16 to 0
    mine_arr = '0;
    set_mine(14, 14); set_mine(0, 14); set_mine(0, 15); set_mine(0, 0);
    run_single(20, 15, 15, 1, 0, "clamp");

    // Zero dimension ignores start
    board_dim = 5'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("dim0_busy",  busy,      0);
    check("dim0_valid", res_valid, 0);
    tick();
    check("dim0_busy2", busy, 0);

    // start together with abort is ignored
    board_dim = 5'd8;
    cell_x    = 4'd2;
    cell_y    = 4'd2;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    tick();
    check("start_abort_busy2", busy,      0);
    check("start_abort_valid", res_valid, 0);

    // Full 8x8 sweep with one mine at (3,4)
    mine_arr = '0;
    set_mine(3, 4);
    start_sweep(8);
    pulses = 0;
    for (int c = 1; c <= 703; c++) begin
      if (c > 1) tick();
      exp_v = (c >= 10) && (((c - 10) % 11) == 0);
      check("sw_valid", res_valid,  exp_v);
      check("sw_busy",  busy,       1);
      check("sw_done",  sweep_done, (c == 703));
      if (res_valid) begin
        ex      = pulses % 8;
        ey      = pulses / 8;
        exp_cnt = ((ex - 3 >= -1) && (ex - 3 <= 1) && (ey - 4 >= -1) && (ey - 4 <= 1) &&
                   !((ex == 3) && (ey == 4))) ? 1 : 0;
        check("sw_x",     res_x,       ex);
        check("sw_y",     res_y,       ey);
        check("sw_count", res_count,   exp_cnt);
        check("sw_mine",  res_is_mine, ((ex == 3) && (ey == 4)));
        check("sw_err",   res_err,     0);
        pulses++;
      end
    end
    check("sw_pulses", pulses, 64);
    tick();
    check("sw_end_busy",  busy,       0);
    check("sw_end_valid", res_valid,  0);
    check("sw_end_done",  sweep_done, 0);

    // Abort during SCAN of cell 5 (cycles 56..64)
    start_sweep(8);
    pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) tick();
      if (res_valid) pulses++;
    end
    check("ab_pulses_before", pulses, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy",   busy,      0);
    check("ab_valid",  res_valid, 0);
    check("ab_hold_x", res_x,     4);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (res_valid || busy) pulses++;
    end
    check("ab_quiet", pulses, 0);
    run_single(8, 3, 3, 1, 0, "post_abort");

    // Abort coincident with EMIT: that result stands, then idle
    start_sweep(8);
    for (int c = 2; c <= 10; c++) tick();
    check("ab_emit_valid", res_valid, 1);
    check("ab_emit_x",     res_x,     0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_emit_busy",  busy,      0);
    check("ab_emit_valid2", res_valid, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (res_valid) pulses++;
    end
    check("ab_emit_quiet", pulses, 0);

    // Asynchronous reset in the middle of a sweep (EMIT of cell 2)
    start_sweep(8);
    for (int c = 2; c <= 32; c++) tick();
    check("rst_pre_valid", res_valid, 1);
    check("rst_pre_x",     res_x,     2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #2;
    rst_n = 1'b1;
    tick();
    check("rst_after_busy",  busy,      0);
    check("rst_after_valid", res_valid, 0);
    run_single(8, 2, 4, 1, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
